data_mem_responder: RTL and testbench

//   Data-memory responder on the processor's data-memory port (CEN/WEN/OEN/A/Data2Mem/ReadDataMem).

---
 rtl/data_mem_responder_if.sv | 55 +++++
 rtl/data_mem_responder.sv | 104 ++++++++++
 tb/tb_data_mem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   Data-memory port between the processor core (master) and the data-memory
//   responder (slave). The signal names follow the core's existing port names.
//
//   Signals
//     CEN          master -> slave  chip enable, active-low
//     WEN          master -> slave  write enable, active-low
//     OEN          master -> slave  output (read) enable, active-low
//     A            master -> slave  word address (AW bits)
//     Data2Mem     master -> slave  write data (DW bits)
//     ReadDataMem  slave -> master  combinational read data (DW bits)
//     err_conflict slave -> master  sticky read/write conflict flag
//     rd_cnt       slave -> master  committed read cycles (CNT_W bits)
//     wr_cnt       slave -> master  committed write cycles (CNT_W bits)
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [AW-1:0]     A;
    logic [DW-1:0]     Data2Mem;
    logic [DW-1:0]     ReadDataMem;
    logic              err_conflict;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (
        output CEN,
        output WEN,
        output OEN,
        output A,
        output Data2Mem,
        input  ReadDataMem,
        input  err_conflict,
        input  rd_cnt,
        input  wr_cnt
    );

    modport slave (
        input  CEN,
        input  WEN,
        input  OEN,
        input  A,
        input  Data2Mem,
        output ReadDataMem,
        output err_conflict,
        output rd_cnt,
        output wr_cnt
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Data-memory responder sitting beside the processor core. Holds DEPTH words
//   of DW bits. Reads are combinational (a load completes in the same cycle),
//   writes commit on the rising edge of clk. A read and a write requested in
//   the same cycle sets a sticky err_conflict flag; the read then returns the
//   old word (no write-to-read bypass).
//
//   Optional feature: define DMEM_STATS_EN to build saturating read/write
//   cycle counters. Without it rd_cnt/wr_cnt are tied to 0 and no counter
//   flops exist.
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous reset, active-low; clears the array, the error
//             flag and the counters, and gates the read data to 0
//     bus     data_mem_responder_if.slave (CEN/WEN/OEN/A/Data2Mem in,
//             ReadDataMem/err_conflict/rd_cnt/wr_cnt out)
//
//   Parameters
//     DEPTH   number of words, must equal 2**AW (A covers the whole array)
//     AW      word address width
//     DW      data width
//     CNT_W   statistics counter width
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    data_mem_responder_if.slave         bus
);

    logic            rd_req;
    logic            wr_req;
    logic [DW-1:0]   mem_q [DEPTH];
    logic            err_conflict_q;

    // Request decode shared by the array, the error flag and the counters.
    assign rd_req = ~bus.CEN & ~bus.OEN;
    assign wr_req = ~bus.CEN & ~bus.WEN;

    // One register per word, each with its own address-match write enable,
    // so the asynchronous clear and the write commit stay per-word.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DW-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (wr_req && (bus.A == AW'(i))) begin
                word_q <= bus.Data2Mem;
            end
        end

        assign mem_q[i] = word_q;
    end

    // The array value seen here is the pre-edge one, so a conflicting
    // read returns the old word.
    assign bus.ReadDataMem = (rst_n && rd_req) ? mem_q[bus.A] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_conflict_q <= 1'b0;
        end else if (rd_req && wr_req) begin
            err_conflict_q <= 1'b1;
        end
    end

    assign bus.err_conflict = err_conflict_q;

`ifdef DMEM_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;

    // Counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
        end else if (rd_req && (rd_cnt_q != {CNT_W{1'b1}})) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else if (wr_req && (wr_cnt_q != {CNT_W{1'b1}})) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
    end

    assign bus.rd_cnt = rd_cnt_q;
    assign bus.wr_cnt = wr_cnt_q;
`else
    assign bus.rd_cnt = {CNT_W{1'b0}};
    assign bus.wr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. Inputs change on the falling
//   edge, outputs are sampled 1 ns later, writes commit on the rising edge.
//   Built with CNT_W=4 so counter saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int CNT_W = 4;
    localparam int DEPTH = 128;

`ifdef DMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    data_mem_responder_if #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) bus ();

    data_mem_responder #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          cen;
        logic          wen;
        logic          oen;
        logic [AW-1:0] a;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;

    task automatic drive(input logic cen, input logic wen, input logic oen,
                         input logic [AW-1:0] a, input logic [DW-1:0] din);
        bus.CEN      = cen;
        bus.WEN      = wen;
        bus.OEN      = oen;
        bus.A        = a;
        bus.Data2Mem = din;
    endtask

    vec_t vecs [14];

    initial begin
        // cen wen oen  a      din            exp_rd         exp_err (before edge)
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 7'h05, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 7'h03, 32'h1,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 7'h03, 32'h0,        32'h1,        1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 7'h03, 32'h2,        32'h1,        1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 7'h03, 32'h0,        32'h2,        1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 7'h09, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 7'h09, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 7'h7F, 32'h12345678, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'h7F, 32'h0,        32'h12345678, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 7'h05, 32'h0BADF00D, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 7'h00, 32'hCAFEF00D, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 7'h00, 32'h0,        32'hCAFEF00D, 1'b1};

        // Reset state, with a read requested so the gating is exercised.
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 7'h00, 32'h0);
        #2;
        check("reset_rdata_gated", bus.ReadDataMem, 32'h0);
        check("reset_err", {31'b0, bus.err_conflict}, 32'h0);
        check("reset_rd_cnt", {28'b0, bus.rd_cnt}, 32'h0);
        check("reset_wr_cnt", {28'b0, bus.wr_cnt}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, AW'(i), 32'h0);
            #1;
            check($sformatf("reset_word_%0d", i), bus.ReadDataMem, 32'h0);
        end
        check("reset_err_after_reads", {31'b0, bus.err_conflict}, 32'h0);

        // Directed vector table.
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            drive(vecs[v].cen, vecs[v].wen, vecs[v].oen, vecs[v].a, vecs[v].din);
            #1;
            check($sformatf("vec%0d_rdata", v), bus.ReadDataMem, vecs[v].exp_rd);
            check($sformatf("vec%0d_err", v), {31'b0, bus.err_conflict}, {31'b0, vecs[v].exp_err});
        end

        // Reset pulse between edges clears a committed word and the flag.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 7'h7F, 32'hA5A5A5A5);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 7'h7F, 32'h0);
        #1;
        check("mid_rst_pre_read", bus.ReadDataMem, 32'hA5A5A5A5);
        check("mid_rst_pre_err", {31'b0, bus.err_conflict}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rdata_gated", bus.ReadDataMem, 32'h0);
        check("mid_rst_err_cleared", {31'b0, bus.err_conflict}, 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("mid_rst_word127", bus.ReadDataMem, 32'h0);
        check("mid_rst_rd_cnt", {28'b0, bus.rd_cnt}, 32'h0);
        check("mid_rst_wr_cnt", {28'b0, bus.wr_cnt}, 32'h0);

        // Reset held across an edge suppresses a pending write.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 7'h7E, 32'h11111111);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 7'h7E, 32'h0);
        #1;
        check("pending_write_dropped", bus.ReadDataMem, 32'h0);
        check("pending_write_err", {31'b0, bus.err_conflict}, 32'h0);

        // Statistics: fresh reset, 20 writes, then one read.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 7'h00, 32'h0);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, AW'(i), 32'(i + 100));
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 7'h09, 32'hFFFFFFFF);
        #1;
        check("stats_wr_cnt_sat", {28'b0, bus.wr_cnt}, STATS ? 32'hF : 32'h0);
        check("stats_rd_cnt_zero", {28'b0, bus.rd_cnt}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 7'd19, 32'h0);
        #1;
        check("stats_word19", bus.ReadDataMem, 32'd119);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 7'h00, 32'h0);
        #1;
        check("stats_rd_cnt_one", {28'b0, bus.rd_cnt}, STATS ? 32'h1 : 32'h0);
        check("stats_wr_cnt_held", {28'b0, bus.wr_cnt}, STATS ? 32'hF : 32'h0);
        check("stats_err_clear", {31'b0, bus.err_conflict}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
